// File: rtl/fxp_mul_add_unit.sv
// fxp_mul_add_unit: registered signed fixed-point multiplier and adder.
// Both datapaths compute an exact full-precision result. They then resize it
// to the output format: LSBs are truncated (floor), and the result saturates
// when the integer part overflows. Results and overflow flags are registered
// together, with one cycle of latency.
module fxp_mul_add_unit #(
    parameter int MA_WI = 4,
    parameter int MA_WF = 5,
    parameter int MB_WI = 4,
    parameter int MB_WF = 5,
    parameter int MO_WI = 6,
    parameter int MO_WF = 8,
    parameter int AA_WI = 6,
    parameter int AA_WF = 8,
    parameter int AB_WI = 6,
    parameter int AB_WF = 8,
    parameter int AO_WI = 6,
    parameter int AO_WF = 8
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   in_valid,
    input  logic [MA_WI+MA_WF-1:0] mul_a,
    input  logic [MB_WI+MB_WF-1:0] mul_b,
    input  logic [AA_WI+AA_WF-1:0] add_a,
    input  logic [AB_WI+AB_WF-1:0] add_b,
    output logic                   out_valid,
    output logic [MO_WI+MO_WF-1:0] mul_out,
    output logic [AO_WI+AO_WF-1:0] add_out,
    output logic                   mul_ovf,
    output logic                   add_ovf,
    output logic [1:0]             ovf_code
);

    // Multiplier widths: exact product, then a common working format wide
    // enough to hold both the product and the output format.
    localparam int MO_W = MO_WI + MO_WF;
    localparam int MP_I = MA_WI + MB_WI;
    localparam int MP_F = MA_WF + MB_WF;
    localparam int MP_W = MP_I + MP_F;
    localparam int MX_I = (MP_I > MO_WI) ? MP_I : MO_WI;
    localparam int MX_F = (MP_F > MO_WF) ? MP_F : MO_WF;
    localparam int MX_W = MX_I + MX_F;
    localparam int MH_W = MX_W - MO_W + 1;

    // Adder widths: operands are aligned to a common format, and one guard
    // integer bit is added so that the sum is exact.
    localparam int AO_W = AO_WI + AO_WF;
    localparam int AS_I = ((AA_WI > AB_WI) ? AA_WI : AB_WI) + 1;
    localparam int AS_F = (AA_WF > AB_WF) ? AA_WF : AB_WF;
    localparam int AS_W = AS_I + AS_F;
    localparam int AX_I = (AS_I > AO_WI) ? AS_I : AO_WI;
    localparam int AX_F = (AS_F > AO_WF) ? AS_F : AO_WF;
    localparam int AX_W = AX_I + AX_F;
    localparam int AH_W = AX_W - AO_W + 1;

    logic signed [MP_W-1:0] mp_full;
    logic signed [MX_W-1:0] mp_ext;
    logic signed [MX_W-1:0] mp_sh;
    logic        [MH_W-1:0] mp_hi;
    logic                   mp_ovf;
    logic        [MO_W-1:0] mp_res;

    logic signed [AS_W-1:0] as_a;
    logic signed [AS_W-1:0] as_b;
    logic signed [AS_W-1:0] as_full;
    logic signed [AX_W-1:0] as_ext;
    logic signed [AX_W-1:0] as_sh;
    logic        [AH_W-1:0] as_hi;
    logic                   as_ovf;
    logic        [AO_W-1:0] as_res;

    // Exact product, then resize it to the multiplier output format.
    // The product is placed in a wide common format. An arithmetic right
    // shift drops the surplus LSBs (floor). The bits above the output's sign
    // bit must then all match that sign bit; otherwise the result saturates.
    always_comb begin
        mp_full = MP_W'($signed(mul_a)) * MP_W'($signed(mul_b));
        mp_ext  = MX_W'(mp_full) <<< (MX_F - MP_F);
        mp_sh   = mp_ext >>> (MX_F - MO_WF);
        mp_hi   = mp_sh[MX_W-1:MO_W-1];
        mp_ovf  = !((mp_hi == '0) || (mp_hi == '1));
        if (mp_ovf) begin
            mp_res = mp_sh[MX_W-1] ? {1'b1, {(MO_W-1){1'b0}}}
                                   : {1'b0, {(MO_W-1){1'b1}}};
        end else begin
            mp_res = mp_sh[MO_W-1:0];
        end
    end

    // Align both operands, form the exact sum, and resize it to the adder
    // output format in the same way as the product.
    always_comb begin
        as_a    = AS_W'($signed(add_a)) <<< (AS_F - AA_WF);
        as_b    = AS_W'($signed(add_b)) <<< (AS_F - AB_WF);
        as_full = as_a + as_b;
        as_ext  = AX_W'(as_full) <<< (AX_F - AS_F);
        as_sh   = as_ext >>> (AX_F - AO_WF);
        as_hi   = as_sh[AX_W-1:AO_W-1];
        as_ovf  = !((as_hi == '0) || (as_hi == '1));
        if (as_ovf) begin
            as_res = as_sh[AX_W-1] ? {1'b1, {(AO_W-1){1'b0}}}
                                   : {1'b0, {(AO_W-1){1'b1}}};
        end else begin
            as_res = as_sh[AO_W-1:0];
        end
    end

    // Output registers: on a valid beat, capture the results and flags.
    // On a bubble, keep the held values and drop out_valid.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            out_valid <= 1'b0;
            mul_out   <= '0;
            add_out   <= '0;
            mul_ovf   <= 1'b0;
            add_ovf   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                mul_out <= mp_res;
                add_out <= as_res;
                mul_ovf <= mp_ovf;
                add_ovf <= as_ovf;
            end
        end
    end

    assign ovf_code = {add_ovf, mul_ovf};

endmodule

// File: tb/tb_fxp_mul_add_unit.sv
// Testbench for fxp_mul_add_unit. It applies directed cases, then random
// cases, and compares every output against a value-level reference model.
module tb_fxp_mul_add_unit;

    localparam int MA_WI = 4;
    localparam int MA_WF = 5;
    localparam int MB_WI = 4;
    localparam int MB_WF = 5;
    localparam int MO_WI = 6;
    localparam int MO_WF = 8;
    localparam int AA_WI = 6;
    localparam int AA_WF = 8;
    localparam int AB_WI = 6;
    localparam int AB_WF = 8;
    localparam int AO_WI = 6;
    localparam int AO_WF = 8;
    localparam int MA_W = MA_WI + MA_WF;
    localparam int MB_W = MB_WI + MB_WF;
    localparam int MO_W = MO_WI + MO_WF;
    localparam int AA_W = AA_WI + AA_WF;
    localparam int AB_W = AB_WI + AB_WF;
    localparam int AO_W = AO_WI + AO_WF;
    localparam int AF   = (AA_WF > AB_WF) ? AA_WF : AB_WF;

    logic            CLK = 1'b0;
    logic            RESET;
    logic            in_valid;
    logic [MA_W-1:0] mul_a;
    logic [MB_W-1:0] mul_b;
    logic [AA_W-1:0] add_a;
    logic [AB_W-1:0] add_b;
    logic            out_valid;
    logic [MO_W-1:0] mul_out;
    logic [AO_W-1:0] add_out;
    logic            mul_ovf;
    logic            add_ovf;
    logic [1:0]      ovf_code;

    int checks = 0;
    int errors = 0;

    // Expected state of the outputs, as held by the reference model.
    logic            e_valid;
    logic [MO_W-1:0] e_mul;
    logic [AO_W-1:0] e_add;
    logic            e_movf;
    logic            e_aovf;

    fxp_mul_add_unit #(
        .MA_WI(MA_WI), .MA_WF(MA_WF), .MB_WI(MB_WI), .MB_WF(MB_WF),
        .MO_WI(MO_WI), .MO_WF(MO_WF), .AA_WI(AA_WI), .AA_WF(AA_WF),
        .AB_WI(AB_WI), .AB_WF(AB_WF), .AO_WI(AO_WI), .AO_WF(AO_WF)
    ) dut (
        .CLK(CLK), .RESET(RESET), .in_valid(in_valid),
        .mul_a(mul_a), .mul_b(mul_b), .add_a(add_a), .add_b(add_b),
        .out_valid(out_valid), .mul_out(mul_out), .add_out(add_out),
        .mul_ovf(mul_ovf), .add_ovf(add_ovf), .ovf_code(ovf_code)
    );

    always #5 CLK = ~CLK;

    // Rescales an exact raw value from fin fractional bits to the format
    // Q(wi.wf). Narrowing floors the value; it is then clamped to the range
    // of the output format.
    function automatic longint rz(input longint x, input int fin, input int wi,
                                  input int wf, output bit ovf);
        longint y, d, hi, lo;
        if (wf >= fin) begin
            y = x * (longint'(1) << (wf - fin));
        end else begin
            d = longint'(1) << (fin - wf);
            y = x / d;
            if ((x % d != 0) && (x < 0)) y = y - 1;
        end
        hi  = (longint'(1) << (wi + wf - 1)) - 1;
        lo  = -hi - 1;
        ovf = 1'b0;
        if (y > hi) begin
            y = hi; ovf = 1'b1;
        end else if (y < lo) begin
            y = lo; ovf = 1'b1;
        end
        return y;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Applies one beat, lets one clock edge pass, updates the model and
    // checks every output.
    task automatic step(input bit rst, input bit v, input int ma, input int mb,
                        input int aa, input int ab, input string tag);
        longint pm, sm, r;
        bit     f;
        RESET    = rst;
        in_valid = v;
        mul_a    = MA_W'(ma);
        mul_b    = MB_W'(mb);
        add_a    = AA_W'(aa);
        add_b    = AB_W'(ab);
        @(posedge CLK);
        #1;
        if (rst) begin
            e_valid = 1'b0; e_mul = '0; e_add = '0; e_movf = 1'b0; e_aovf = 1'b0;
        end else begin
            e_valid = v;
            if (v) begin
                pm = longint'($signed(mul_a)) * longint'($signed(mul_b));
                r  = rz(pm, MA_WF + MB_WF, MO_WI, MO_WF, f);
                e_mul = MO_W'(r); e_movf = f;
                sm = longint'($signed(add_a)) * (longint'(1) << (AF - AA_WF))
                   + longint'($signed(add_b)) * (longint'(1) << (AF - AB_WF));
                r  = rz(sm, AF, AO_WI, AO_WF, f);
                e_add = AO_W'(r); e_aovf = f;
            end
        end
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(e_valid));
        chk({tag, ".mul_out"},   32'(mul_out),   32'(e_mul));
        chk({tag, ".add_out"},   32'(add_out),   32'(e_add));
        chk({tag, ".mul_ovf"},   32'(mul_ovf),   32'(e_movf));
        chk({tag, ".add_ovf"},   32'(add_ovf),   32'(e_aovf));
        chk({tag, ".ovf_code"},  32'(ovf_code),  32'({e_aovf, e_movf}));
    endtask

    initial begin
        RESET = 1'b1; in_valid = 1'b0;
        mul_a = '0; mul_b = '0; add_a = '0; add_b = '0;

        // Reset held for two edges while in_valid is high.
        step(1, 1, 224, 224, 5120, 3840, "rst0");
        step(1, 1, 224, 224, 5120, 3840, "rst1");
        // First valid beat after reset.
        step(0, 1, 48, 64, 2560, -640, "mul_1p5x2");
        step(0, 1, -48, 64, 0, 0, "mul_m1p5x2");
        step(0, 1, 224, 224, 0, 0, "mul_sat_pos");
        step(0, 1, -224, 224, 0, 0, "mul_sat_neg");
        step(0, 1, 1, 1, 0, 0, "mul_trunc0");
        step(0, 1, -1, 1, 0, 0, "mul_floor");
        step(0, 1, 0, 0, 5120, 3840, "add_sat_pos");
        step(0, 1, 0, 0, -5120, -3840, "add_sat_neg");
        step(0, 1, 0, 0, 2560, -640, "add_10m2p5");
        step(0, 1, 224, 224, 5120, 3840, "both_ovf");
        step(0, 1, 48, 64, 2560, -640, "ovf_clear");
        // Reset in the cycle after a valid beat.
        step(0, 1, 224, -224, -5120, -3840, "pre_rst");
        step(1, 0, 0, 0, 0, 0, "mid_rst");
        // Bubble: in_valid 1,0,1 with the outputs held during the bubble.
        step(0, 1, 48, 64, 2560, -640, "bub_v1");
        step(0, 0, 224, 224, 5120, 3840, "bub_hold");
        step(0, 1, -48, 64, -5120, -3840, "bub_v2");

        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
                 int'($urandom), int'($urandom), int'($urandom), int'($urandom),
                 "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
